// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB3 round-robin master: FSM encoding and an index-width helper.
package apb_arb_pkg;

   // Encoding kept identical to the APB slave so waveforms line up.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB3 bus between the arbitrating master and a single slave.
// Handshake: a transfer completes on the first ACCESS cycle (psel & penable) with pready=1;
// paddr/pwrite/pwdata hold from SETUP until that cycle.
interface apb_master_arbiter_if #(
   parameter int ADDR       = 5,
   parameter int DATA_WIDTH = 32
) ();
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR-1:0]       paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pready;
   logic                  pslverr;
   logic [DATA_WIDTH-1:0] prdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, pslverr, prdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, pslverr, prdata
   );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first unmasked request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic            any
);

   always_comb begin
      int idx;
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && req[idx] && !mask[idx]) begin
            grant[idx] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 master shared by NREQ requesters through round-robin arbitration.
// Optional ACCESS timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR       = 5,
   parameter int TIMEOUT    = 16
) (
   input  logic                       pclk,
   input  logic                       preset,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*ADDR-1:0]       req_addr,
   input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]            gnt,
   output logic [NREQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]      rdata,
   output logic                       err,
   apb_master_arbiter_if.master       apb,
   output arb_state_t                 state
);

   localparam int IW = clog2(NREQ);

   arb_state_t            state_d;
   logic [IW-1:0]         ptr_q, ptr_d, gidx_q, gidx_d, arb_ptr, win_idx;
   logic [NREQ-1:0]       gnt_q, gnt_d, done_q, done_d, win;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, pwdata_q, pwdata_d;
   logic                  err_q, err_d, psel_q, psel_d, penable_q, penable_d;
   logic                  pwrite_q, pwrite_d, any, launch, abort;
   logic [ADDR-1:0]       paddr_q, paddr_d;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      if (i == IW'(NREQ - 1)) return '0;
      return i + 1'b1;
   endfunction

   // In the completing ACCESS cycle the pointer already behaves as if advanced past the
   // winner; masking the winner (and the done cycle) stops a held req being served twice.
   assign arb_ptr = (state == ACCESS) ? next_idx(gidx_q) : ptr_q;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req   (req),
      .mask  (gnt_q | done_q),
      .ptr   (arb_ptr),
      .grant (win),
      .any   (any)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (win[i]) win_idx = IW'(i);
   end

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = clog2(TIMEOUT) + 1;
   logic [CW-1:0] tcnt_q;

   always_ff @(posedge pclk) begin
      if (preset || state != ACCESS) tcnt_q <= '0;
      else                           tcnt_q <= tcnt_q + 1'b1;
   end

   assign abort = (state == ACCESS) && !apb.pready && (tcnt_q == CW'(TIMEOUT - 1));
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d   = state;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      launch    = 1'b0;
      unique case (state)
         IDLE:  launch = any;
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: if (apb.pready || abort) begin
            done_d    = gnt_q;
            err_d     = abort ? 1'b1 : apb.pslverr;
            rdata_d   = (abort || pwrite_q) ? '0 : apb.prdata;
            ptr_d     = next_idx(gidx_q);
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            gnt_d     = '0;
            launch    = any && !abort;
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d   = SETUP;
         gidx_d    = win_idx;
         gnt_d     = win;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = req_write[win_idx];
         paddr_d   = req_addr[int'(win_idx)*ADDR +: ADDR];
         pwdata_d  = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state     <= state_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign gnt         = gnt_q;
   assign done        = done_q;
   assign rdata       = rdata_q;
   assign err         = err_q;
   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB slave model (32 words, err at addr >= 21).
module tb_apb_master_arbiter;
   import apb_arb_pkg::*;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int AW   = 5;

   logic              pclk;
   logic              preset;
   logic [NREQ-1:0]   req, req_write, gnt, done;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]     rdata;
   logic              err;
   arb_state_t        state;

   int n_err = 0;
   int n_checks = 0;

   apb_master_arbiter_if #(.ADDR(AW), .DATA_WIDTH(DW)) apb ();

   apb_master_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR(AW), .TIMEOUT(16)) dut (
      .pclk      (pclk),
      .preset    (preset),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .apb       (apb.master),
      .state     (state)
   );

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // slave model: wait_cfg wait states per access, stuck holds pready low
   logic [DW-1:0] mem [32];
   int   wcnt = 0;
   int   wait_cfg = 0;
   logic stuck = 1'b0;

   assign apb.pready  = !stuck && (wcnt == wait_cfg);
   assign apb.pslverr = apb.pready && (apb.paddr >= 5'd21);
   assign apb.prdata  = (apb.pready && apb.paddr < 5'd21) ? mem[apb.paddr] : '0;

   always @(posedge pclk) begin
      if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 1;
      else                                        wcnt <= 0;
      if (apb.psel && apb.penable && apb.pready && apb.pwrite && !apb.pslverr)
         mem[apb.paddr] <= apb.pwdata;
   end

   // driver tasks
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]                = 1'b1;
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic wait_done(input int limit, output int cycles);
      cycles = 0;
      while (done == '0 && cycles < limit) begin
         tick();
         cycles++;
      end
   endtask

   function automatic int oh2i(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return 99;
   endfunction

   // scoreboard for grant order
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   initial begin
      int c, pen_cnt, done_cnt, bad, drops;
      logic [NREQ-1:0] done_val;

      preset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      tick(); tick();
      check("rst_psel", apb.psel, 0);
      check("rst_penable", apb.penable, 0);
      check("rst_gnt_done", {gnt, done}, 0);
      check("rst_rdata_err", {rdata, err}, 0);
      check("rst_addr_data", {apb.paddr, apb.pwdata, apb.pwrite}, 0);
      check("rst_state", state, IDLE);
      preset = 1'b0;

      // 1: single write, zero wait states
      set_req(0, 1'b1, 5'd3, 32'hA5A5_0001);
      tick();
      check("t1_c1_psel_pen", {apb.psel, apb.penable}, 2'b10);
      check("t1_c1_gnt", gnt, 4'b0001);
      check("t1_c1_cmd", {apb.pwrite, apb.paddr, apb.pwdata}, {1'b1, 5'd3, 32'hA5A5_0001});
      tick();
      check("t1_c2_psel_pen", {apb.psel, apb.penable}, 2'b11);
      tick();
      check("t1_c3_done", done, 4'b0001);
      check("t1_c3_err_rdata", {err, rdata}, 0);
      check("t1_c3_idle", {apb.psel, apb.penable, gnt}, 0);
      req = '0;
      tick();
      check("t1_done_pulse", done, 0);

      // 2: read back through requester 2, then error address
      set_req(2, 1'b0, 5'd3, 32'h0);
      wait_done(10, c);
      check("t2_lat", c, 3);
      check("t2_done", done, 4'b0100);
      check("t2_rdata", rdata, 32'hA5A5_0001);
      check("t2_err", err, 0);
      req = '0;
      tick();
      set_req(2, 1'b0, 5'd25, 32'h0);
      wait_done(10, c);
      check("t2e_done", done, 4'b0100);
      check("t2e_err", err, 1);
      check("t2e_rdata", rdata, 0);
      req = '0;
      tick();

      // 3: all four held, pointer restarted at 0
      preset = 1'b1;
      tick();
      preset = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(8 + i), 32'h100 + i);
      exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
      drops = 0; bad = 0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (!apb.psel) drops++;
         if (apb.penable !== ((k % 2) == 0)) bad++;
         if (done != '0) got_q.push_back(8'(oh2i(done)));
      end
      check("t3_psel_drops", drops, 0);
      check("t3_penable_pattern", bad, 0);
      check("t3_ndone", got_q.size(), 5);
      for (int i = 0; i < 5; i++)
         check("t3_order", (i < got_q.size()) ? got_q[i] : 8'hFF, exp_q[i]);
      req = '0;
      tick();
      wait_done(5, c);
      check("t3_drain_done", done, 4'b0010);
      check("t3_drain_idle", {apb.psel, gnt}, 0);

      // 4: three wait states
      wait_cfg = 3;
      set_req(1, 1'b1, 5'd7, 32'h1234_5678);
      pen_cnt = 0; done_cnt = 0; bad = 0; done_val = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (apb.penable) pen_cnt++;
         if (apb.psel && (apb.paddr !== 5'd7 || apb.pwdata !== 32'h1234_5678)) bad++;
         if (done != '0) begin
            done_cnt++;
            done_val = done;
            req = '0;
         end
      end
      check("t4_penable_cycles", pen_cnt, 4);
      check("t4_cmd_stable", bad, 0);
      check("t4_done_count", done_cnt, 1);
      check("t4_done_bit", done_val, 4'b0010);

      // 5: reset in ACCESS, restart favours requester 0
      set_req(3, 1'b0, 5'd9, 32'h0);
      tick();
      check("t5_gnt", gnt, 4'b1000);
      tick();
      check("t5_access", state, ACCESS);
      preset = 1'b1;
      set_req(0, 1'b1, 5'd10, 32'hBEEF);
      tick();
      check("t5_rst_bus", {apb.psel, apb.penable, gnt, done}, 0);
      check("t5_rst_state", state, IDLE);
      preset = 1'b0;
      wait_cfg = 0;
      tick();
      check("t5_restart_gnt", {apb.psel, gnt}, {1'b1, 4'b0001});
      tick(); tick();
      check("t5_done0", done, 4'b0001);
      req[0] = 1'b0;
      tick(); tick();
      check("t5_done3", done, 4'b1000);
      req = '0;
      tick();

      // 6: pready stuck low
      stuck = 1'b1;
      set_req(2, 1'b0, 5'd5, 32'h0);
`ifdef APB_ARB_TIMEOUT_EN
      pen_cnt = 0; c = 0;
      while (done == '0 && c < 40) begin
         tick();
         c++;
         if (apb.penable) pen_cnt++;
      end
      check("t6_abort_cycle", c, 18);
      check("t6_penable_cycles", pen_cnt, 16);
      check("t6_done", done, 4'b0100);
      check("t6_err", err, 1);
      check("t6_rdata", rdata, 0);
      check("t6_bus_idle", {apb.psel, apb.penable}, 0);
      req = '0;
      stuck = 1'b0;
      tick();
`else
      done_cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (done != '0) done_cnt++;
      end
      check("t6_no_done", done_cnt, 0);
      check("t6_waiting", {apb.psel, apb.penable, gnt}, {2'b11, 4'b0100});
      check("t6_state", state, ACCESS);
      req = '0;
      stuck = 1'b0;
      preset = 1'b1;
      tick();
      preset = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
